// File: rtl/fb_write_ctrl.sv
// Byte decoder and back-buffer write sequencer for the double-buffered SPI framebuffer.
// Optional build macro FB_AUTO_SWAP_EN: a completed frame requests a swap automatically.
module fb_write_ctrl #(
  parameter int RES_X      = 320,
  parameter int RES_Y      = 240,
  parameter int ADDR_WIDTH = $clog2(RES_X*RES_Y)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  input  logic                  frame_start,
  output logic                  fb_we,
  output logic [ADDR_WIDTH-1:0] fb_waddr,
  output logic [5:0]            fb_wdata,
  output logic                  fb_wsel,
  output logic                  front_sel,
  output logic                  swap_pending,
  output logic                  swap_done,
  output logic                  frame_done,
  output logic [ADDR_WIDTH-1:0] addr_count,
  output logic [7:0]            drop_cnt
);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RES_X*RES_Y-1);

  typedef enum logic {STREAM, SWAP_WAIT} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] next_addr, next_addr_nxt;
  logic [ADDR_WIDTH-1:0] fb_waddr_nxt, addr_count_nxt, wr_addr;
  logic [5:0]            fb_wdata_nxt;
  logic [7:0]            drop_cnt_nxt;
  logic                  fb_we_nxt, front_sel_nxt, swap_pending_nxt, swap_done_nxt, frame_done_nxt;
  logic                  is_pix, is_align, is_swap, swap_req, swap_exec, wr;

  assign fb_wsel = ~front_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= STREAM;
      next_addr    <= '0;
      fb_we        <= 1'b0;
      fb_waddr     <= '0;
      fb_wdata     <= '0;
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
      frame_done   <= 1'b0;
      addr_count   <= '0;
      drop_cnt     <= '0;
    end else begin
      state        <= state_nxt;
      next_addr    <= next_addr_nxt;
      fb_we        <= fb_we_nxt;
      fb_waddr     <= fb_waddr_nxt;
      fb_wdata     <= fb_wdata_nxt;
      front_sel    <= front_sel_nxt;
      swap_pending <= swap_pending_nxt;
      swap_done    <= swap_done_nxt;
      frame_done   <= frame_done_nxt;
      addr_count   <= addr_count_nxt;
      drop_cnt     <= drop_cnt_nxt;
    end
  end

  always_comb begin
    is_pix    = rx_valid && !rx_byte[7];
    is_align  = rx_valid && (rx_byte == 8'h80);
    is_swap   = rx_valid && (rx_byte == 8'h81);
`ifdef FB_AUTO_SWAP_EN
    swap_req  = is_swap || frame_done;
`else
    swap_req  = is_swap;
`endif
    swap_exec = (state == SWAP_WAIT) && frame_start;
    // A pixel arriving with the swap lands at the start of the new back buffer.
    wr        = is_pix && ((state == STREAM) || swap_exec);
    wr_addr   = swap_exec ? '0 : next_addr;

    state_nxt        = state;
    next_addr_nxt    = next_addr;
    fb_we_nxt        = 1'b0;
    fb_waddr_nxt     = fb_waddr;
    fb_wdata_nxt     = fb_wdata;
    front_sel_nxt    = front_sel;
    swap_pending_nxt = swap_pending;
    swap_done_nxt    = 1'b0;
    frame_done_nxt   = 1'b0;
    addr_count_nxt   = addr_count;
    drop_cnt_nxt     = drop_cnt;

    case (state)
      STREAM: begin
        if (swap_req) begin
          state_nxt        = SWAP_WAIT;
          swap_pending_nxt = 1'b1;
        end
      end
      SWAP_WAIT: begin
        if (frame_start) begin
          state_nxt        = STREAM;
          swap_pending_nxt = 1'b0;
          front_sel_nxt    = ~front_sel;
          swap_done_nxt    = 1'b1;
          next_addr_nxt    = '0;
        end else if (is_pix && (drop_cnt != 8'hFF)) begin
          drop_cnt_nxt = drop_cnt + 8'd1;
        end
      end
      default: state_nxt = STREAM;
    endcase

    if (is_align) begin
      next_addr_nxt  = '0;
      addr_count_nxt = '0;
    end

    if (is_pix) fb_wdata_nxt = rx_byte[5:0];

    if (wr) begin
      fb_we_nxt      = 1'b1;
      fb_waddr_nxt   = wr_addr;
      addr_count_nxt = wr_addr;
      frame_done_nxt = (wr_addr == LAST_ADDR);
      next_addr_nxt  = (wr_addr == LAST_ADDR) ? '0 : wr_addr + 1'b1;
    end
  end

endmodule
